ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) from the FPGA to the keyboard on the same PS2_CLK/PS2_DAT pair that keyboard_press_driver listens on. It drives both lines open-drain: it only pulls them low or releases them, and the top level ties the pad to 0 when drive_low=1 and to Z otherwise. It holds rx_inhibit high while active so the receive path ignores the host-generated frame.

Parameters:
INHIBIT_CYCLES, 6000, CLOCK_50 cycles CLK is held low before the request (120 us)
START_TIMEOUT, 750000, cycles allowed from CLK release to the first device falling edge (15 ms)
XFER_TIMEOUT, 100000, cycles allowed from the first falling edge to the ACK edge (2 ms)
TIMER_W, 20, timer width; must hold the largest of the three above

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset
PS2_CLK  in  1  raw PS/2 clock pad value, asynchronous
PS2_DAT  in  1  raw PS/2 data pad value, asynchronous
ps2_clk_drive_low  out  1  1 = pull PS2_CLK low
ps2_dat_drive_low  out  1  1 = pull PS2_DAT low
tx_data  in  8  byte to send
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
tx_done  out  1  one-cycle pulse: frame ACKed by the device
tx_error  out  1  one-cycle pulse: frame failed
tx_err_code  out  2  held until the next accept; 0 none, 1 start timeout, 2 transfer timeout, 3 no ACK
rx_inhibit  out  1  high in every state except IDLE

Behaviour:
- Input synchronisation
  - PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser, then a 4-sample-agreement glitch filter.
  - fall = filtered CLK goes 1 to 0. Worst-case detection latency from the pad is 6 cycles.
- Reset (asynchronous, low)
  - State = IDLE; both drive_low outputs = 0 (lines released immediately); tx_ready = 1.
  - tx_done = tx_error = 0; tx_err_code = 0; rx_inhibit = 0; internal bit counter and timer = 0.
  - A reset in the middle of a frame abandons it. There is no done or error pulse.
- Accept
  - In IDLE with tx_valid = 1: latch tx_data and parity = ~^tx_data (odd parity).
  - Clear tx_err_code, enter INHIBIT. tx_valid in any other state is ignored.
- State machine
  - IDLE: both lines released.
  - INHIBIT: clk_low = 1, dat_low = 0 for INHIBIT_CYCLES. Then enter REQ.
  - REQ: dat_low = 1 (start bit 0), clk_low = 0 from the first REQ cycle; the timer restarts.
    - fall arrives: shift register loads {stop=1, parity, data[7:0]}; drive bit0 (dat_low = ~bit); bit count = 1; restart the timer; enter DATA.
    - START_TIMEOUT expires first: error code 1.
  - DATA: on each fall, drive the next bit, LSB first.
    - Falls 2..8 drive data[1..7].
    - Fall 9 drives parity.
    - Fall 10 releases DAT (stop bit), then enter ACK.
    - Total elapsed time reaching XFER_TIMEOUT: error code 2.
  - ACK: on fall 11, sample filtered DAT.
    - DAT = 0: enter WAIT_IDLE.
    - DAT = 1: error code 3.
    - Total time reaching XFER_TIMEOUT: error code 2.
  - WAIT_IDLE: wait until filtered CLK = 1 and DAT = 1 together. Then pulse tx_done for 1 cycle and return to IDLE. XFER_TIMEOUT also applies here (code 2).
  - ERR: release both lines, pulse tx_error for 1 cycle, latch the code, return to IDLE next cycle.
- Data change rule: line changes occur the cycle after the fall is detected, never on a rising edge.
- Simultaneous timeout and fall in the same cycle: the timeout wins.

Decomposition:
- Package ps2_pkg:
  - tx_state_t enum: IDLE, INHIBIT, REQ, DATA, ACK, WAIT_IDLE, ERR.
  - err_code_t: ERR_NONE, ERR_START_TO, ERR_XFER_TO, ERR_NO_ACK.
  - Command constants: CMD_SET_LEDS = 8'hED, CMD_RESET = 8'hFF, CMD_ENABLE = 8'hF4.
- Sub-module ps2_line_sync: synchroniser plus glitch filter plus fall-edge pulse, one instance per line. Reusable by the receive path.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz that ACKs:
  - CLK held low 6000 cycles, then DAT low.
  - Sampled bits on rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_err_code = 0.
- Send 0x01 and 0x00: parity observed is 0 and 1 respectively; frames ACKed.
- Device model never clocks: tx_error pulses 750000 cycles after the REQ entry, code = 1, both lines released.
- Device clocks 11 edges but leaves DAT high at the ACK edge: tx_error pulses, code = 3, no tx_done.
- Device stops clocking after fall 5: code = 2 at 100000 cycles after fall 1.
- Two further cases:
  - Assert reset (low) mid-DATA: both drive_low outputs = 0 in the same cycle; tx_ready = 1 after release.
  - tx_valid held during a frame: no second frame starts until IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared types and constants for the PS/2 host transmit path:
//               FSM state encoding, error codes and common command bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Transmit FSM state encoding
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t IDLE      = 3'd0;
    localparam tx_state_t INHIBIT   = 3'd1;
    localparam tx_state_t REQ       = 3'd2;
    localparam tx_state_t DATA      = 3'd3;
    localparam tx_state_t ACK       = 3'd4;
    localparam tx_state_t WAIT_IDLE = 3'd5;
    localparam tx_state_t ERR       = 3'd6;

    // Failure reason reported on tx_err_code
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_START_TO = 2'd1,
        ERR_XFER_TO  = 2'd2,
        ERR_NO_ACK   = 2'd3
    } err_code_t;

    // Common keyboard command bytes
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_line_sync
// Description : Brings one raw PS/2 pad into the system clock domain through
//               a 2-flop synchroniser, a 4-sample agreement glitch filter and
//               a registered falling-edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pad,
    output logic o_level,
    output logic o_fall
);

    logic       r_sync1;
    logic       r_sync2;
    logic [2:0] r_hist;
    logic       r_level;
    logic       r_fall;
    logic       w_all_hi;
    logic       w_all_lo;

    // Filtered level only moves once four consecutive samples agree
    assign w_all_hi = r_sync2 & (&r_hist);
    assign w_all_lo = ~r_sync2 & ~(|r_hist);

    // Synchronise, keep sample history, update filtered level and fall pulse.
    // Idle PS/2 lines are high, so everything resets to 1 to avoid a false fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 3'b111;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_pad;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[1:0], r_sync2};
            if (w_all_hi) begin
                r_level <= 1'b1;
            end else if (w_all_lo) begin
                r_level <= 1'b0;
            end
            r_fall  <= r_level & w_all_lo;
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_tx
// Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//               request-to-send, shifts one byte plus odd parity and stop out
//               on device clock falls, and checks the device ACK. Both lines
//               are driven open-drain through the *_drive_low outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int START_TIMEOUT  = 750000,
    parameter int XFER_TIMEOUT   = 100000,
    parameter int TIMER_W        = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_drive_low,
    output logic       ps2_dat_drive_low,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code,
    output logic       rx_inhibit
);

    localparam logic [TIMER_W-1:0] c_inhibit_last = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] c_start_last   = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_xfer_last    = TIMER_W'(XFER_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] c_timer_one    = TIMER_W'(1);

    tx_state_t          r_state;
    logic [9:0]         r_shift;
    logic [3:0]         r_bit_cnt;
    logic [TIMER_W-1:0] r_timer;
    logic               r_clk_low;
    logic               r_dat_low;
    logic               r_done;
    logic               r_error;
    err_code_t          r_err_code;
    err_code_t          r_err_pend;

    logic               w_clk_level;
    logic               w_clk_fall;
    logic               w_dat_level;
    logic               w_dat_fall_unused;
    logic               w_xfer_to;

    ps2_line_sync u_clk_sync (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .i_pad   (PS2_CLK),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clk     (CLOCK_50),
        .rst_n   (reset),
        .i_pad   (PS2_DAT),
        .o_level (w_dat_level),
        .o_fall  (w_dat_fall_unused)
    );

    // One timer covers the whole frame from the first device fall onwards
    assign w_xfer_to = (r_timer == c_xfer_last);

    // Transmit FSM; line drives are registered so they change only the cycle
    // after a fall is seen. A timeout is checked before the fall so it wins.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_timer    <= '0;
            r_clk_low  <= 1'b0;
            r_dat_low  <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
            r_err_pend <= ERR_NONE;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_clk_low <= 1'b0;
                    r_dat_low <= 1'b0;
                    if (tx_valid) begin
                        r_shift    <= {1'b1, odd_parity(tx_data), tx_data};
                        r_err_code <= ERR_NONE;
                        r_timer    <= '0;
                        r_clk_low  <= 1'b1;
                        r_state    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (r_timer == c_inhibit_last) begin
                        r_timer   <= '0;
                        r_clk_low <= 1'b0;
                        r_dat_low <= 1'b1;
                        r_state   <= REQ;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                REQ: begin
                    if (r_timer == c_start_last) begin
                        r_err_pend <= ERR_START_TO;
                        r_clk_low  <= 1'b0;
                        r_dat_low  <= 1'b0;
                        r_state    <= ERR;
                    end else if (w_clk_fall) begin
                        r_dat_low <= ~r_shift[0];
                        r_shift   <= {1'b0, r_shift[9:1]};
                        r_bit_cnt <= 4'd1;
                        r_timer   <= '0;
                        r_state   <= DATA;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                    end
                end
                DATA: begin
                    if (w_xfer_to) begin
                        r_err_pend <= ERR_XFER_TO;
                        r_clk_low  <= 1'b0;
                        r_dat_low  <= 1'b0;
                        r_state    <= ERR;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                        if (w_clk_fall) begin
                            // Falls 2..9 drive data[1..7] then parity; fall 10 drives the stop bit (release)
                            r_dat_low <= ~r_shift[0];
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd9) begin
                                r_state <= ACK;
                            end
                        end
                    end
                end
                ACK: begin
                    if (w_xfer_to) begin
                        r_err_pend <= ERR_XFER_TO;
                        r_state    <= ERR;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                        if (w_clk_fall) begin
                            if (!w_dat_level) begin
                                r_state <= WAIT_IDLE;
                            end else begin
                                r_err_pend <= ERR_NO_ACK;
                                r_state    <= ERR;
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (w_xfer_to) begin
                        r_err_pend <= ERR_XFER_TO;
                        r_state    <= ERR;
                    end else begin
                        r_timer <= r_timer + c_timer_one;
                        if (w_clk_level && w_dat_level) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    r_clk_low  <= 1'b0;
                    r_dat_low  <= 1'b0;
                    r_error    <= 1'b1;
                    r_err_code <= r_err_pend;
                    r_state    <= IDLE;
                end
                default: begin
                    r_clk_low <= 1'b0;
                    r_dat_low <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign ps2_clk_drive_low = r_clk_low;
    assign ps2_dat_drive_low = r_dat_low;
    assign tx_ready          = (r_state == IDLE);
    assign rx_inhibit        = (r_state != IDLE);
    assign tx_done           = r_done;
    assign tx_error          = r_error;
    assign tx_err_code       = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_tx
// Description : Self-checking bench for ps2_host_tx with a behavioural PS/2
//               device on a wired-AND bus and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int c_inh   = 100;
    localparam int c_start = 1500;
    localparam int c_xfer  = 1200;
    localparam int c_half  = 20;

    logic       CLOCK_50;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       dev_clk;
    logic       dev_dat;
    logic       pad_clk;
    logic       pad_dat;
    logic       ps2_clk_drive_low;
    logic       ps2_dat_drive_low;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] tx_err_code;
    logic       rx_inhibit;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         cyc      = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         err_cyc  = 0;
    logic [1:0] err_lines = 2'b00;
    logic [1:0] err_code_at_pulse = 2'b00;

    // Open-drain bus: either side can pull a line low
    assign pad_clk = dev_clk & ~ps2_clk_drive_low;
    assign pad_dat = dev_dat & ~ps2_dat_drive_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (c_inh),
        .START_TIMEOUT  (c_start),
        .XFER_TIMEOUT   (c_xfer),
        .TIMER_W        (20)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .PS2_CLK           (pad_clk),
        .PS2_DAT           (pad_dat),
        .ps2_clk_drive_low (ps2_clk_drive_low),
        .ps2_dat_drive_low (ps2_dat_drive_low),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_done           (tx_done),
        .tx_error          (tx_error),
        .tx_err_code       (tx_err_code),
        .rx_inhibit        (rx_inhibit)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Cycle counter
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Pulse monitors sampled on the inactive edge
    always @(negedge CLOCK_50) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt           <= err_cnt + 1;
            err_cyc           <= cyc;
            err_lines         <= {ps2_clk_drive_low, ps2_dat_drive_low};
            err_code_at_pulse <= tx_err_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: odd parity means the total count of ones including parity is odd
    function automatic logic model_parity(input logic [7:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Reference line values: [0] start, [1..8] data LSB first, [9] parity, [10] stop
    function automatic logic [10:0] model_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = model_parity(d);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge CLOCK_50);
        check("ready_before_accept", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
        check("ready_low_active", tx_ready, 0);
        check("rx_inhibit_active", rx_inhibit, 1);
        check("err_code_cleared", tx_err_code, 0);
    endtask

    // Behavioural keyboard: observe inhibit and request, then clock nfalls edges
    task automatic dev_run(input int nfalls, input bit ack, input bit drop_valid,
                           output logic [10:0] frame, output int inh,
                           output int t_req, output int t_fall1);
        int w;
        frame = '1; inh = 0; t_req = 0; t_fall1 = 0; w = 0;
        while (!ps2_clk_drive_low && w < 400) begin
            @(negedge CLOCK_50);
            w++;
        end
        if (drop_valid) tx_valid = 1'b0;
        while (ps2_clk_drive_low && inh < c_inh + 50) begin
            inh++;
            @(negedge CLOCK_50);
        end
        t_req = cyc;
        check("req_dat_low", ps2_dat_drive_low, 1);
        repeat ($urandom_range(5, 40)) @(negedge CLOCK_50);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && ack) dev_dat = 1'b0;
            repeat (c_half) @(negedge CLOCK_50);
            if (k == 1) begin
                frame[0] = pad_dat;
                t_fall1  = cyc;
            end
            dev_clk = 1'b0;
            repeat (c_half) @(negedge CLOCK_50);
            if (k <= 10) frame[k] = pad_dat;
            dev_clk = 1'b1;
        end
        if (nfalls == 11) begin
            repeat (c_half) @(negedge CLOCK_50);
            dev_dat = 1'b1;
        end
    endtask

    task automatic wait_done(input int target);
        for (int w = 0; w < 300 && done_cnt < target; w++) @(negedge CLOCK_50);
    endtask

    task automatic wait_err(input int target, input int bound);
        for (int w = 0; w < bound && err_cnt < target; w++) @(negedge CLOCK_50);
    endtask

    task automatic send_ok(input logic [7:0] d, output logic [10:0] frame);
        int inh, t_req, t1, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d);
        dev_run(11, 1'b1, 1'b0, frame, inh, t_req, t1);
        check("inhibit_len", inh, c_inh);
        check("frame_bits", frame, model_frame(d));
        wait_done(d0 + 1);
        repeat (5) @(negedge CLOCK_50);
        check("done_pulses", done_cnt - d0, 1);
        check("no_error", err_cnt - e0, 0);
        check("err_code_none", tx_err_code, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [10:0] f;
        logic [7:0]  a, b;
        int          inh, t_req, t1, d0, e0, delta;

        reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_dat = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_ready", tx_ready, 1);
        check("rst_clk_drive", ps2_clk_drive_low, 0);
        check("rst_dat_drive", ps2_dat_drive_low, 0);
        check("rst_rx_inhibit", rx_inhibit, 0);
        check("rst_done", tx_done, 0);
        check("rst_error", tx_error, 0);
        check("rst_err_code", tx_err_code, 0);
        reset = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Directed commands
        send_ok(CMD_SET_LEDS, f);
        check("led_frame_literal", f, 11'b11111011010);
        send_ok(8'h01, f);
        check("parity_01", f[9], 0);
        send_ok(8'h00, f);
        check("parity_00", f[9], 1);
        send_ok(CMD_RESET, f);
        send_ok(CMD_ENABLE, f);

        // Random bytes
        for (int i = 0; i < 6; i++) begin
            send_ok(8'($urandom_range(0, 255)), f);
        end

        // Device never clocks
        d0 = done_cnt; e0 = err_cnt;
        start_tx(CMD_ENABLE);
        dev_run(0, 1'b0, 1'b0, f, inh, t_req, t1);
        wait_err(e0 + 1, c_start + 100);
        check("start_to_seen", err_cnt - e0, 1);
        check("start_to_code", err_code_at_pulse, 1);
        check("start_to_lines", err_lines, 0);
        delta = err_cyc - t_req;
        check("start_to_time", (delta >= c_start && delta <= c_start + 2), 1);
        repeat (4) @(negedge CLOCK_50);
        check("start_to_code_held", tx_err_code, 1);
        check("start_to_no_done", done_cnt - d0, 0);

        // Device leaves DAT high at the ACK edge
        a = 8'($urandom_range(0, 255));
        d0 = done_cnt; e0 = err_cnt;
        start_tx(a);
        dev_run(11, 1'b0, 1'b0, f, inh, t_req, t1);
        check("noack_frame_bits", f, model_frame(a));
        wait_err(e0 + 1, 200);
        repeat (3) @(negedge CLOCK_50);
        check("noack_seen", err_cnt - e0, 1);
        check("noack_code", err_code_at_pulse, 3);
        check("noack_no_done", done_cnt - d0, 0);

        // Device stops after fall 5
        e0 = err_cnt;
        start_tx(8'($urandom_range(0, 255)));
        dev_run(5, 1'b1, 1'b0, f, inh, t_req, t1);
        wait_err(e0 + 1, c_xfer + 200);
        check("xfer_to_seen", err_cnt - e0, 1);
        check("xfer_to_code", err_code_at_pulse, 2);
        check("xfer_to_lines", err_lines, 0);
        delta = err_cyc - t1;
        check("xfer_to_time", (delta >= c_xfer + 6 && delta <= c_xfer + 10), 1);

        // Reset in the middle of DATA with DAT pulled low
        a = 8'($urandom_range(0, 255)) & 8'hFB;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(a);
        dev_run(3, 1'b1, 1'b0, f, inh, t_req, t1);
        check("pre_reset_dat_low", ps2_dat_drive_low, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_clk_drive", ps2_clk_drive_low, 0);
        check("mid_rst_dat_drive", ps2_dat_drive_low, 0);
        check("mid_rst_ready", tx_ready, 1);
        repeat (5) @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_no_done", done_cnt - d0, 0);
        check("post_rst_no_error", err_cnt - e0, 0);

        // tx_valid held through a frame: second frame only after IDLE
        a = 8'($urandom_range(0, 255));
        b = a ^ 8'h5A;
        d0 = done_cnt;
        @(negedge CLOCK_50);
        tx_data = a; tx_valid = 1'b1;
        @(negedge CLOCK_50);
        tx_data = b;
        dev_run(11, 1'b1, 1'b0, f, inh, t_req, t1);
        check("held_frame1_bits", f, model_frame(a));
        check("held_frame1_inhibit", inh, c_inh);
        dev_run(11, 1'b1, 1'b1, f, inh, t_req, t1);
        check("held_frame2_bits", f, model_frame(b));
        wait_done(d0 + 2);
        repeat (30) @(negedge CLOCK_50);
        check("held_done_pulses", done_cnt - d0, 2);
        check("held_idle_after", tx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
